// File: rtl/nec_ir_pkg.sv
// Shared types and constants for the NEC IR receive path.
package nec_ir_pkg;

  localparam int NEC_FRAME_W = 17;

  // Decoded NEC frame as produced by the receive datapath.
  typedef struct packed {
    logic       repeat_flag;
    logic [7:0] addr;
    logic [7:0] data;
  } nec_frame_t;

endpackage

// File: rtl/nec_ir_rx_fifo.sv
// Receive frame FIFO: circular buffer with one slot kept empty, wrapping
// ASIZE-bit pointers, pop-style registered read port and sticky overflow.
module nec_ir_rx_fifo
  import nec_ir_pkg::*;
#(
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  nec_frame_t       i_wdata,
  input  logic             i_rd_req,
  input  logic             i_ovf_clr,
  output logic             o_rd_ack,
  output nec_frame_t       o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [ASIZE-1:0] o_count,
  output logic             o_ovf
);

  localparam int               DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE-1:0] PTR_ONE = {{(ASIZE-1){1'b0}}, 1'b1};

  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  nec_frame_t       r_mem [DEPTH];
  logic             r_rd_ack;
  nec_frame_t       r_rd_data;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovf_set;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = ((r_wptr + PTR_ONE) == r_rptr);
  assign w_pop     = !i_flush && i_rd_req && !w_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // still succeeds when it coincides with a pop.
  assign w_push    = !i_flush && i_wr && (!w_full || w_pop);
  assign w_ovf_set = !i_flush && i_wr && w_full && !w_pop;

  // Pointer update; disabling the receiver flushes by zeroing both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Frame storage; a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers alone define validity,
    // and leaving it unreset lets it map onto plain RAM.
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Registered read port; rd_data holds its value when no pop occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rptr];
    end
  end

  // Sticky overflow; a same-cycle set beats the clear. Survives a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (i_ovf_clr) r_ovf <= 1'b0;
  end

  assign o_rd_ack  = r_rd_ack;
  assign o_rd_data = r_rd_data;
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_wptr - r_rptr;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/nec_ir_rx_ctrl.sv
// NEC IR receive control: tick8 prescaler, receive FIFO and interrupt.
// Optional feature macro: NEC_IR_RX_IRQ_EN enables the level/overflow irq;
// without it irq is tied low and cfg_irq_thresh is ignored.
module nec_ir_rx_ctrl
  import nec_ir_pkg::*;
#(
  parameter int PSIZE = 32,
  parameter int ASIZE = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_receiver_en,
  input  logic [PSIZE-1:0]       cfg_prescaler,
  input  logic [ASIZE-1:0]       cfg_irq_thresh,
  output logic                   tick8,
  input  logic [NEC_FRAME_W-1:0] fifo_rx_wdata,
  input  logic                   fifo_rx_write,
  input  logic                   rd_req,
  output logic                   rd_ack,
  output logic [NEC_FRAME_W-1:0] rd_data,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [ASIZE-1:0]       fifo_count,
  output logic                   ovf_flag,
  input  logic                   ovf_clr,
  output logic                   irq
);

  localparam logic [PSIZE-1:0] PCNT_ONE = {{(PSIZE-1){1'b0}}, 1'b1};

  logic [PSIZE-1:0] r_pcnt;
  logic             r_tick8;

  nec_frame_t       w_wframe;
  nec_frame_t       w_rd_frame;
  logic [ASIZE-1:0] w_count;
  logic             w_ovf;

  // Prescaler: strobe and reload at zero; a new period applies at reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt  <= '0;
      r_tick8 <= 1'b0;
    end else if (!cfg_receiver_en) begin
      r_pcnt  <= cfg_prescaler;
      r_tick8 <= 1'b0;
    end else if (r_pcnt == '0) begin
      r_pcnt  <= cfg_prescaler;
      r_tick8 <= 1'b1;
    end else begin
      r_pcnt  <= r_pcnt - PCNT_ONE;
      r_tick8 <= 1'b0;
    end
  end

  assign tick8    = r_tick8;
  assign w_wframe = fifo_rx_wdata;

  nec_ir_rx_fifo #(
    .ASIZE(ASIZE)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (!cfg_receiver_en),
    .i_wr      (fifo_rx_write),
    .i_wdata   (w_wframe),
    .i_rd_req  (rd_req),
    .i_ovf_clr (ovf_clr),
    .o_rd_ack  (rd_ack),
    .o_rd_data (w_rd_frame),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full),
    .o_count   (w_count),
    .o_ovf     (w_ovf)
  );

  assign rd_data    = w_rd_frame;
  assign fifo_count = w_count;
  assign ovf_flag   = w_ovf;

`ifdef NEC_IR_RX_IRQ_EN
  logic r_irq;

  // Interrupt: FIFO level at/above a non-zero threshold, or overflow pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= ((cfg_irq_thresh != '0) && (w_count >= cfg_irq_thresh)) || w_ovf;
  end

  assign irq = r_irq;
`else
  logic w_unused_thresh;

  assign w_unused_thresh = ^cfg_irq_thresh;
  assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_nec_ir_rx_ctrl.sv
// Directed self-checking bench for nec_ir_rx_ctrl (PSIZE=32, ASIZE=3).
module tb_nec_ir_rx_ctrl;

`ifdef NEC_IR_RX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_receiver_en = 1'b0;
  logic [31:0] cfg_prescaler = '0;
  logic [2:0]  cfg_irq_thresh = '0;
  logic        tick8;
  logic [16:0] fifo_rx_wdata = '0;
  logic        fifo_rx_write = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [16:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        ovf_flag;
  logic        ovf_clr = 1'b0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nec_ir_rx_ctrl #(.PSIZE(32), .ASIZE(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_receiver_en (cfg_receiver_en),
    .cfg_prescaler   (cfg_prescaler),
    .cfg_irq_thresh  (cfg_irq_thresh),
    .tick8           (tick8),
    .fifo_rx_wdata   (fifo_rx_wdata),
    .fifo_rx_write   (fifo_rx_write),
    .rd_req          (rd_req),
    .rd_ack          (rd_ack),
    .rd_data         (rd_data),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .fifo_count      (fifo_count),
    .ovf_flag        (ovf_flag),
    .ovf_clr         (ovf_clr),
    .irq             (irq)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [16:0] d);
    fifo_rx_write = 1'b1;
    fifo_rx_wdata = d;
    step();
    fifo_rx_write = 1'b0;
  endtask

  task automatic do_pop();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  // Pop once and compare the returned frame.
  task automatic pop_expect(input string name, input logic [16:0] exp);
    do_pop();
    n_tests++;
    if (rd_ack !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL %s: got ack=%b data=%h expected ack=1 data=%h", name, rd_ack, rd_data, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({tick8, rd_ack, rd_data, fifo_empty, fifo_full, fifo_count, ovf_flag, irq} !==
        {1'b0, 1'b0, 17'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got tick8=%b ack=%b data=%h empty=%b full=%b count=%0d ovf=%b irq=%b",
               tick8, rd_ack, rd_data, fifo_empty, fifo_full, fifo_count, ovf_flag, irq);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_prescaler();
    cfg_receiver_en = 1'b0;
    cfg_prescaler   = 32'd0;
    step();
    cfg_prescaler   = 32'd4;
    cfg_receiver_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (tick8 !== (k == 1 || k == 6 || k == 11)) begin
        n_fail++;
        $display("FAIL presc4_cycle%0d: got tick8=%b expected %b", k, tick8, (k == 1 || k == 6 || k == 11));
      end
    end
    cfg_receiver_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (tick8 !== 1'b0) begin
        n_fail++;
        $display("FAIL presc_disabled_%0d: got tick8=%b expected 0", k, tick8);
      end
    end
    cfg_prescaler = 32'd0;
    step();
    cfg_receiver_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_tests++;
      if (tick8 !== 1'b1) begin
        n_fail++;
        $display("FAIL presc0_cycle%0d: got tick8=%b expected 1", k, tick8);
      end
    end
  endtask

  task automatic test_fill_overflow();
    cfg_irq_thresh = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      do_write(17'(i));
      n_tests++;
      if (fifo_count !== 3'(i) || fifo_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_count_%0d: got count=%0d empty=%b expected count=%0d empty=0", i, fifo_count, fifo_empty, i);
      end
    end
    n_tests++;
    if (fifo_full !== 1'b1 || ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b ovf=%b expected full=1 ovf=0", fifo_full, ovf_flag);
    end
    do_write(17'h1ABCD);
    n_tests++;
    if (ovf_flag !== 1'b1 || fifo_count !== 3'd7 || fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b count=%0d full=%b expected ovf=1 count=7 full=1", ovf_flag, fifo_count, fifo_full);
    end
    for (int i = 1; i <= 7; i++) pop_expect("fill_pop_order", 17'(i));
    n_tests++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0 || fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drained: got empty=%b count=%0d full=%b expected empty=1 count=0 full=0", fifo_empty, fifo_count, fifo_full);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%b expected 0", ovf_flag);
    end
  endtask

  task automatic test_full_write_pop();
    for (int i = 1; i <= 7; i++) do_write(17'h00100 + 17'(i));
    fifo_rx_write = 1'b1;
    fifo_rx_wdata = 17'h0AAAA;
    rd_req        = 1'b1;
    step();
    fifo_rx_write = 1'b0;
    rd_req        = 1'b0;
    n_tests++;
    if (rd_ack !== 1'b1 || rd_data !== 17'h00101 || fifo_count !== 3'd7 || ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL full_wr_pop: got ack=%b data=%h count=%0d ovf=%b expected ack=1 data=00101 count=7 ovf=0",
               rd_ack, rd_data, fifo_count, ovf_flag);
    end
    for (int i = 2; i <= 7; i++) pop_expect("full_wr_pop_order", 17'h00100 + 17'(i));
    pop_expect("full_wr_pop_new", 17'h0AAAA);
    n_tests++;
    if (fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_wr_pop_empty: got empty=%b expected 1", fifo_empty);
    end
  endtask

  task automatic test_empty_pop();
    do_pop();
    n_tests++;
    if (rd_ack !== 1'b0 || rd_data !== 17'h0AAAA || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL empty_pop: got ack=%b data=%h count=%0d expected ack=0 data=0aaaa count=0", rd_ack, rd_data, fifo_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      do_write(17'h10000 + 17'(i * 37));
      pop_expect("wrap_pair", 17'h10000 + 17'(i * 37));
    end
    n_tests++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_end: got empty=%b count=%0d expected empty=1 count=0", fifo_empty, fifo_count);
    end
  endtask

  task automatic test_irq();
    cfg_irq_thresh = 3'd3;
    do_write(17'h00011);
    do_write(17'h00022);
    do_write(17'h00033);
    n_tests++;
    if (fifo_count !== 3'd3 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_level_latency: got count=%0d irq=%b expected count=3 irq=0", fifo_count, irq);
    end
    step();
    n_tests++;
    if (irq !== IRQ_ON) begin
      n_fail++;
      $display("FAIL irq_level_set: got irq=%b expected %b", irq, IRQ_ON);
    end
    pop_expect("irq_pop", 17'h00011);
    step();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_level_clear: got irq=%b expected 0", irq);
    end
    pop_expect("irq_drain", 17'h00022);
    pop_expect("irq_drain", 17'h00033);
    cfg_irq_thresh = 3'd0;
    for (int i = 0; i < 8; i++) do_write(17'h00200 + 17'(i));
    step();
    n_tests++;
    if (ovf_flag !== 1'b1 || irq !== IRQ_ON) begin
      n_fail++;
      $display("FAIL irq_ovf_set: got ovf=%b irq=%b expected ovf=1 irq=%b", ovf_flag, irq, IRQ_ON);
    end
    step();
    n_tests++;
    if (irq !== IRQ_ON) begin
      n_fail++;
      $display("FAIL irq_ovf_hold: got irq=%b expected %b", irq, IRQ_ON);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
    n_tests++;
    if (ovf_flag !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_ovf_clear: got ovf=%b irq=%b expected ovf=0 irq=0", ovf_flag, irq);
    end
    cfg_receiver_en = 1'b0;
    step();
    cfg_receiver_en = 1'b1;
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) do_write(17'h00300 + 17'(i));
    do_pop();
    do_pop();
    do_pop();
    n_tests++;
    if (fifo_count !== 3'd4 || ovf_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: got count=%0d ovf=%b expected count=4 ovf=1", fifo_count, ovf_flag);
    end
    cfg_receiver_en = 1'b0;
    step();
    n_tests++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0 || ovf_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: got empty=%b count=%0d ovf=%b expected empty=1 count=0 ovf=1", fifo_empty, fifo_count, ovf_flag);
    end
    do_write(17'h1FFFF);
    n_tests++;
    if (fifo_count !== 3'd0 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_write_ignored: got count=%0d empty=%b expected count=0 empty=1", fifo_count, fifo_empty);
    end
    cfg_receiver_en = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ovf_clr: got ovf=%b expected 0", ovf_flag);
    end
  endtask

  task automatic test_async_reset();
    cfg_prescaler = 32'd0;
    do_write(17'h00401);
    do_write(17'h00402);
    do_write(17'h00403);
    fifo_rx_write = 1'b1;
    fifo_rx_wdata = 17'h00404;
    rd_req        = 1'b1;
    @(posedge clk);
    #2;
    n_tests++;
    if (rd_ack !== 1'b1 || rd_data !== 17'h00401 || tick8 !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_before_reset: got ack=%b data=%h tick8=%b expected ack=1 data=00401 tick8=1", rd_ack, rd_data, tick8);
    end
    rst_n = 1'b0;
    #1;
    fifo_rx_write = 1'b0;
    rd_req        = 1'b0;
    n_tests++;
    if ({tick8, rd_ack, rd_data, fifo_empty, fifo_full, fifo_count, ovf_flag, irq} !==
        {1'b0, 1'b0, 17'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got tick8=%b ack=%b data=%h empty=%b full=%b count=%0d ovf=%b irq=%b",
               tick8, rd_ack, rd_data, fifo_empty, fifo_full, fifo_count, ovf_flag, irq);
    end
    step();
    rst_n = 1'b1;
    step();
    do_pop();
    n_tests++;
    if (rd_ack !== 1'b0 || rd_data !== 17'h0 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discards: got ack=%b data=%h empty=%b expected ack=0 data=0 empty=1", rd_ack, rd_data, fifo_empty);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_prescaler();
    test_fill_overflow();
    test_full_write_pop();
    test_empty_pop();
    test_wrap();
    test_irq();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
